// File: rtl/skin_pkg.sv
// skin_pkg: shared constants and types for the skin-threshold slice.
//   - default Cb/Cr skin window bounds
//   - coordinate width X_W and pixel-count width CNT_W
//   - frame statistics record, its accumulator start value and an update helper
package skin_pkg;

   localparam int unsigned X_W   = 11;
   localparam int unsigned CNT_W = 21;

   localparam logic [7:0] CB_MIN_DEF = 8'd77;
   localparam logic [7:0] CB_MAX_DEF = 8'd127;
   localparam logic [7:0] CR_MIN_DEF = 8'd133;
   localparam logic [7:0] CR_MAX_DEF = 8'd173;

   localparam logic [X_W-1:0]   XY_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef struct packed {
      logic [CNT_W-1:0] count;
      logic [X_W-1:0]   x_min;
      logic [X_W-1:0]   x_max;
      logic [X_W-1:0]   y_min;
      logic [X_W-1:0]   y_max;
   } skin_stats_t;

   // Empty-frame start value: mins at the top of range so the first pixel wins.
   localparam skin_stats_t ACC_INIT = '{
      count: '0,
      x_min: XY_MAX,
      x_max: '0,
      y_min: XY_MAX,
      y_max: '0
   };

   localparam skin_stats_t STATS_RST = '0;

   // Fold one skin pixel at (x, y) into a statistics record.
   function automatic skin_stats_t stats_add(input skin_stats_t s,
                                             input logic [X_W-1:0] x,
                                             input logic [X_W-1:0] y);
      skin_stats_t r;
      r = s;
      if (s.count != CNT_MAX) r.count = s.count + 1'b1;
      if (x < s.x_min) r.x_min = x;
      if (x > s.x_max) r.x_max = x;
      if (y < s.y_min) r.y_min = y;
      if (y > s.y_max) r.y_max = y;
      return r;
   endfunction

endpackage

// File: rtl/skin_frame_stats.sv
// skin_frame_stats: per-frame skin statistics.
//   clk, rst              : clock, synchronous active-high reset
//   in_de, in_vsync       : input-side timing (same cycle as is_skin)
//   is_skin               : current pixel classified as skin (already gated by in_de)
//   skin_count            : skin pixels in the last completed frame
//   x_min/x_max/y_min/y_max : bounding box of the last completed frame
//   stats_valid           : one-cycle pulse when the outputs above update
module skin_frame_stats
   import skin_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_de,
   input  logic        in_vsync,
   input  logic        is_skin,
   output logic [20:0] skin_count,
   output logic [10:0] x_min,
   output logic [10:0] x_max,
   output logic [10:0] y_min,
   output logic [10:0] y_max,
   output logic        stats_valid
);

   logic [X_W-1:0] x_q, x_d;
   logic [X_W-1:0] y_q, y_d;
   logic           de_prev_q, de_prev_d;
   logic           vs_prev_q, vs_prev_d;
   skin_stats_t    acc_q, acc_d;
   skin_stats_t    stats_q, stats_d;
   logic           valid_q, valid_d;

   logic           vs_rise;
   logic           de_fall;
   skin_stats_t    acc_base;

   always_comb begin
      vs_rise   = in_vsync & ~vs_prev_q;
      de_fall   = ~in_de & de_prev_q;
      de_prev_d = in_de;
      vs_prev_d = in_vsync;

      // Column counter: x_q is the column of the pixel currently on the input.
      x_d = x_q;
      if (in_de) begin
         if (x_q != XY_MAX) x_d = x_q + 1'b1;
      end else if (de_prev_q) begin
         x_d = '0;
      end

      y_d = y_q;
      if (vs_rise) begin
         y_d = '0;
      end else if (de_fall) begin
         if (y_q != XY_MAX) y_d = y_q + 1'b1;
      end

      // On a vsync edge the current pixel (if skin) seeds the fresh
      // accumulator rather than the frame being reported.
      acc_base = vs_rise ? ACC_INIT : acc_q;
      acc_d    = is_skin ? stats_add(acc_base, x_q, y_q) : acc_base;

      stats_d = vs_rise ? acc_q : stats_q;
      valid_d = vs_rise;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q       <= '0;
         y_q       <= '0;
         de_prev_q <= 1'b0;
         vs_prev_q <= 1'b1;
         acc_q     <= ACC_INIT;
         stats_q   <= STATS_RST;
         valid_q   <= 1'b0;
      end else begin
         x_q       <= x_d;
         y_q       <= y_d;
         de_prev_q <= de_prev_d;
         vs_prev_q <= vs_prev_d;
         acc_q     <= acc_d;
         stats_q   <= stats_d;
         valid_q   <= valid_d;
      end
   end

   assign skin_count  = stats_q.count;
   assign x_min       = stats_q.x_min;
   assign x_max       = stats_q.x_max;
   assign y_min       = stats_q.y_min;
   assign y_max       = stats_q.y_max;
   assign stats_valid = valid_q;

endmodule

// File: rtl/skin_threshold.sv
// skin_threshold: YCbCr skin classifier with per-frame statistics.
//   clk, rst                     : clock, synchronous active-high reset
//   Y, Cb, Cr                    : input pixel (Y unused)
//   in_hsync, in_vsync, in_de    : input timing, aligned with the pixel
//   mask                         : 8'hFF for skin, 8'h00 otherwise (2-cycle latency)
//   out_hsync, out_vsync, out_de : input timing delayed 2 cycles, aligned with mask
//   skin_count, x_min..y_max     : last completed frame statistics
//   stats_valid                  : one-cycle pulse when statistics update
module skin_threshold
   import skin_pkg::*;
#(
   parameter logic [7:0] CB_MIN = CB_MIN_DEF,
   parameter logic [7:0] CB_MAX = CB_MAX_DEF,
   parameter logic [7:0] CR_MIN = CR_MIN_DEF,
   parameter logic [7:0] CR_MAX = CR_MAX_DEF
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  Y,
   input  logic [7:0]  Cb,
   input  logic [7:0]  Cr,
   input  logic        in_hsync,
   input  logic        in_vsync,
   input  logic        in_de,
   output logic [7:0]  mask,
   output logic        out_hsync,
   output logic        out_vsync,
   output logic        out_de,
   output logic [20:0] skin_count,
   output logic [10:0] x_min,
   output logic [10:0] x_max,
   output logic [10:0] y_min,
   output logic [10:0] y_max,
   output logic        stats_valid
);

   // Stage 1: compare flags and timing.
   logic cb_ok_q, cb_ok_d;
   logic cr_ok_q, cr_ok_d;
   logic de1_q, hs1_q, vs1_q;
   // Stage 2: mask and timing.
   logic [7:0] mask_q, mask_d;
   logic       de2_q, hs2_q, vs2_q;

   logic is_skin;
   logic unused_y;

   assign unused_y = ^Y;

   always_comb begin
      cb_ok_d = (Cb >= CB_MIN) && (Cb <= CB_MAX);
      cr_ok_d = (Cr >= CR_MIN) && (Cr <= CR_MAX);
      is_skin = in_de & cb_ok_d & cr_ok_d;
      mask_d  = (de1_q && cb_ok_q && cr_ok_q) ? 8'hFF : 8'h00;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cb_ok_q <= 1'b0;
         cr_ok_q <= 1'b0;
         de1_q   <= 1'b0;
         hs1_q   <= 1'b0;
         vs1_q   <= 1'b0;
         mask_q  <= 8'h00;
         de2_q   <= 1'b0;
         hs2_q   <= 1'b0;
         vs2_q   <= 1'b0;
      end else begin
         cb_ok_q <= cb_ok_d;
         cr_ok_q <= cr_ok_d;
         de1_q   <= in_de;
         hs1_q   <= in_hsync;
         vs1_q   <= in_vsync;
         mask_q  <= mask_d;
         de2_q   <= de1_q;
         hs2_q   <= hs1_q;
         vs2_q   <= vs1_q;
      end
   end

   assign mask      = mask_q;
   assign out_de    = de2_q;
   assign out_hsync = hs2_q;
   assign out_vsync = vs2_q;

   skin_frame_stats u_stats (
      .clk         (clk),
      .rst         (rst),
      .in_de       (in_de),
      .in_vsync    (in_vsync),
      .is_skin     (is_skin),
      .skin_count  (skin_count),
      .x_min       (x_min),
      .x_max       (x_max),
      .y_min       (y_min),
      .y_max       (y_max),
      .stats_valid (stats_valid)
   );

endmodule

// File: tb/tb_skin_threshold.sv
// tb_skin_threshold: directed bench for skin_threshold.
module tb_skin_threshold;

   logic        clk;
   logic        rst;
   logic [7:0]  Y, Cb, Cr;
   logic        in_hsync, in_vsync, in_de;
   logic [7:0]  mask;
   logic        out_hsync, out_vsync, out_de;
   logic [20:0] skin_count;
   logic [10:0] x_min, x_max, y_min, y_max;
   logic        stats_valid;

   int n_checks = 0;
   int n_errors = 0;

   skin_threshold #(
      .CB_MIN(8'd77),
      .CB_MAX(8'd127),
      .CR_MIN(8'd133),
      .CR_MAX(8'd173)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .Y           (Y),
      .Cb          (Cb),
      .Cr          (Cr),
      .in_hsync    (in_hsync),
      .in_vsync    (in_vsync),
      .in_de       (in_de),
      .mask        (mask),
      .out_hsync   (out_hsync),
      .out_vsync   (out_vsync),
      .out_de      (out_de),
      .skin_count  (skin_count),
      .x_min       (x_min),
      .x_max       (x_max),
      .y_min       (y_min),
      .y_max       (y_max),
      .stats_valid (stats_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pixel vectors: Cb, Cr, de and hand-computed mask.
   logic [7:0] vec_cb  [10] = '{8'd100, 8'd128, 8'd77,  8'd127, 8'd76,  8'd100, 8'd100, 8'd77,  8'd127, 8'd100};
   logic [7:0] vec_cr  [10] = '{8'd150, 8'd150, 8'd133, 8'd173, 8'd150, 8'd174, 8'd132, 8'd173, 8'd133, 8'd150};
   logic       vec_de  [10] = '{1'b1,   1'b1,   1'b1,   1'b1,   1'b1,   1'b1,   1'b1,   1'b1,   1'b1,   1'b0};
   logic [7:0] vec_exp [10] = '{8'hFF,  8'h00,  8'hFF,  8'hFF,  8'h00,  8'h00,  8'h00,  8'hFF,  8'hFF,  8'h00};

   logic [31:0] hs_pat = 32'hF0F0_3C5A;
   logic [31:0] vs_pat = 32'h00FF_0F33;
   logic [31:0] de_pat = 32'hA5C3_7E19;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One frame of h lines, w active pixels each, 3 blanking cycles per line.
   task automatic send_frame(input int w, input int h,
                             input int sx0, input int sy0, input int sx1, input int sy1);
      for (int yy = 0; yy < h; yy++) begin
         for (int xx = 0; xx < w; xx++) begin
            in_de = 1'b1;
            Cr    = 8'd150;
            Cb    = ((xx == sx0 && yy == sy0) || (xx == sx1 && yy == sy1)) ? 8'd100 : 8'd128;
            tick;
         end
         in_de = 1'b0;
         Cb    = 8'd128;
         tick; tick; tick;
      end
   endtask

   // Vsync pulse; optionally a skin pixel on the rising-edge cycle.
   task automatic vsync_pulse(input bit chk, input bit seed, input int e_cnt,
                              input int e_xmin, input int e_xmax,
                              input int e_ymin, input int e_ymax);
      in_vsync = 1'b1;
      in_de    = seed;
      Cb       = seed ? 8'd100 : 8'd128;
      Cr       = 8'd150;
      tick;
      if (chk) begin
         check_val("stats_valid_hi", 32'(stats_valid), 32'd1);
         check_val("skin_count",     32'(skin_count),  32'(e_cnt));
         check_val("x_min",          32'(x_min),       32'(e_xmin));
         check_val("x_max",          32'(x_max),       32'(e_xmax));
         check_val("y_min",          32'(y_min),       32'(e_ymin));
         check_val("y_max",          32'(y_max),       32'(e_ymax));
      end
      in_de = 1'b0;
      Cb    = 8'd128;
      tick;
      if (chk) check_val("stats_valid_lo", 32'(stats_valid), 32'd0);
      in_vsync = 1'b0;
      tick; tick;
   endtask

   initial begin
      logic [7:0] prev_mask;
      logic       p_hs, p_vs, p_de;

      // Reset with busy inputs.
      rst = 1'b1; Y = 8'h40; Cb = 8'd100; Cr = 8'd150;
      in_hsync = 1'b1; in_vsync = 1'b1; in_de = 1'b1;
      tick; tick;
      check_val("rst_mask",   32'(mask),        32'd0);
      check_val("rst_hsync",  32'(out_hsync),   32'd0);
      check_val("rst_vsync",  32'(out_vsync),   32'd0);
      check_val("rst_de",     32'(out_de),      32'd0);
      check_val("rst_valid",  32'(stats_valid), 32'd0);
      check_val("rst_count",  32'(skin_count),  32'd0);
      check_val("rst_xmin",   32'(x_min),       32'd0);
      check_val("rst_xmax",   32'(x_max),       32'd0);
      check_val("rst_ymin",   32'(y_min),       32'd0);
      check_val("rst_ymax",   32'(y_max),       32'd0);

      rst = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0; in_de = 1'b0; Cb = 8'd128;
      tick; tick;
      check_val("rel_mask",  32'(mask),        32'd0);
      check_val("rel_valid", 32'(stats_valid), 32'd0);

      // Classification and 2-cycle latency.
      prev_mask = 8'h00;
      for (int i = 0; i < 10; i++) begin
         Cb = vec_cb[i]; Cr = vec_cr[i]; in_de = vec_de[i];
         tick;
         check_val("mask_lat1", 32'(mask), 32'(prev_mask));
         tick;
         check_val("mask_lat2", 32'(mask), 32'(vec_exp[i]));
         prev_mask = vec_exp[i];
      end
      in_de = 1'b0; Cb = 8'd128; Cr = 8'd150;
      tick; tick;

      // Timing delay with a skin pixel value held on the bus.
      Cb = 8'd100; Cr = 8'd150;
      p_hs = 1'b0; p_vs = 1'b0; p_de = 1'b0;
      for (int i = 0; i < 32; i++) begin
         in_hsync = hs_pat[i]; in_vsync = vs_pat[i]; in_de = de_pat[i];
         tick;
         check_val("dly_hsync", 32'(out_hsync), 32'(p_hs));
         check_val("dly_vsync", 32'(out_vsync), 32'(p_vs));
         check_val("dly_de",    32'(out_de),    32'(p_de));
         check_val("dly_mask",  32'(mask),      p_de ? 32'hFF : 32'h00);
         p_hs = hs_pat[i]; p_vs = vs_pat[i]; p_de = de_pat[i];
      end
      in_hsync = 1'b0; in_vsync = 1'b0; in_de = 1'b0; Cb = 8'd128;
      tick; tick; tick;

      // 8x4 frame, skin at (2,1) and (5,3).
      vsync_pulse(1'b0, 1'b0, 0, 0, 0, 0, 0);
      send_frame(8, 4, 2, 1, 5, 3);
      vsync_pulse(1'b1, 1'b0, 2, 2, 5, 1, 3);

      // Frame without skin.
      send_frame(8, 4, -1, -1, -1, -1);
      vsync_pulse(1'b1, 1'b0, 0, 2047, 0, 2047, 0);

      // Partial frame, then reset with vsync already high across release.
      send_frame(8, 2, 7, 0, 0, 1);
      in_de = 1'b1; Cb = 8'd100; Cr = 8'd150;
      tick; tick;
      rst = 1'b1; in_vsync = 1'b1; in_de = 1'b0; Cb = 8'd128;
      for (int i = 0; i < 3; i++) begin
         tick;
         check_val("midrst_valid", 32'(stats_valid), 32'd0);
      end
      rst = 1'b0;
      tick;
      check_val("post_rst_valid0", 32'(stats_valid), 32'd0);
      tick;
      check_val("post_rst_valid1", 32'(stats_valid), 32'd0);
      in_vsync = 1'b0;
      tick; tick;
      // Post-reset partial frame saw no pixels: pre-reset pixels are gone.
      vsync_pulse(1'b1, 1'b0, 0, 2047, 0, 2047, 0);

      // Full frame; closing edge carries a skin pixel at (0,4).
      send_frame(8, 4, 3, 2, 4, 0);
      vsync_pulse(1'b1, 1'b1, 2, 3, 4, 0, 2);
      vsync_pulse(1'b1, 1'b0, 1, 0, 0, 4, 4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no end of stimulus expected completion");
      $fatal(1);
   end

endmodule
